clk_div_ctrl: RTL and testbench



---
 rtl/clk_div_ctrl_pkg.sv | 18 +
 rtl/clk_div_ctrl_rr_arbiter.sv | 34 +++
 rtl/clk_div_ctrl.sv | 144 ++++++++++++++
 tb/tb_clk_div_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and constants for the clock-divider configuration controller.
package clk_div_ctrl_pkg;

  localparam int RATIO_W = 8;

  // Ratios 0 and 1 both put the divider in bypass.
  localparam logic [RATIO_W-1:0] RATIO_BYPASS0 = 8'd0;
  localparam logic [RATIO_W-1:0] RATIO_BYPASS1 = 8'd1;

  typedef enum logic [2:0] {
    IDLE,
    GATE,
    LOAD,
    SETTLE,
    ACK
  } state_t;

endpackage

// File: rtl/clk_div_ctrl_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last owner and wraps.
module rr_arbiter
  import clk_div_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  input  logic               gnt_stb,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  int   cand;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = last_owner;
    found   = 1'b0;
    cand    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_owner) + i) % NUM_REQ;
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
    // The index is always driven; the one-hot grant only fires on the strobe.
    if (found && gnt_stb) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Arbitrated, glitch-safe reprogramming of an integer clock divider.
// Optional macro CLK_DIV_CTRL_LOCK_EN adds i_cfg_lock / o_nack.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter  int                 NUM_REQ     = 2,
  parameter  int                 HOLD_CYCLES = 2,
  parameter  logic [RATIO_W-1:0] RESET_RATIO = 8'd1,
  localparam int                 IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                       i_ref_clk,
  input  logic                       i_rst_n,
`ifdef CLK_DIV_CTRL_LOCK_EN
  input  logic                       i_cfg_lock,
  output logic [NUM_REQ-1:0]         o_nack,
`endif
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [RATIO_W*NUM_REQ-1:0] i_req_ratio,
  output logic [NUM_REQ-1:0]         o_ack,
  output logic                       o_busy,
  output logic [IDX_W-1:0]           o_owner,
  output logic                       o_clk_en,
  output logic [RATIO_W-1:0]         o_div_ratio
);

  localparam logic [RATIO_W-1:0] HOLD_TC = RATIO_W'(HOLD_CYCLES - 1);

  state_t               state;
  logic [RATIO_W-1:0]   hold_cnt;
  logic [RATIO_W-1:0]   settle_cnt;
  logic [RATIO_W-1:0]   ratio_q;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic [IDX_W-1:0]     gnt_idx;
  logic [NUM_REQ-1:0]   owner_oh;
  logic [RATIO_W-1:0]   req_ratio_sel;
  logic                 any_req;
  logic                 grant_now;
  logic                 lock_now;

  // Terminal count for SETTLE: one full divided period, bypass ratios count as 1.
  function automatic logic [RATIO_W-1:0] settle_terminal(input logic [RATIO_W-1:0] r);
    if (r == RATIO_BYPASS0 || r == RATIO_BYPASS1) return '0;
    return r - RATIO_W'(1);
  endfunction

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req       (i_req),
    .last_owner(o_owner),
    .gnt_stb   (state == IDLE),
    .gnt       (gnt_oh),
    .gnt_idx   (gnt_idx)
  );

  assign any_req       = |i_req;
  assign grant_now     = (state == IDLE) && any_req;
  assign req_ratio_sel = i_req_ratio[gnt_idx*RATIO_W +: RATIO_W];
  assign owner_oh      = NUM_REQ'(1) << o_owner;

`ifdef CLK_DIV_CTRL_LOCK_EN
  assign lock_now = i_cfg_lock;
`else
  assign lock_now = 1'b0;
`endif

  // Ratio capture at grant; pure data, no reset needed.
  always_ff @(posedge i_ref_clk) begin
    if (grant_now) ratio_q <= req_ratio_sel;
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      settle_cnt  <= '0;
      o_ack       <= '0;
      o_busy      <= 1'b0;
      o_owner     <= IDX_W'(NUM_REQ - 1);
      o_clk_en    <= 1'b0;
      o_div_ratio <= RESET_RATIO;
`ifdef CLK_DIV_CTRL_LOCK_EN
      o_nack      <= '0;
`endif
    end else begin
      o_ack <= '0;
`ifdef CLK_DIV_CTRL_LOCK_EN
      o_nack <= '0;
`endif
      case (state)
        IDLE: begin
          if (any_req) begin
            o_owner <= gnt_idx;
            o_busy  <= 1'b1;
            if (lock_now) begin
              state <= ACK;
`ifdef CLK_DIV_CTRL_LOCK_EN
              o_nack <= gnt_oh;
`endif
            end else if (req_ratio_sel == o_div_ratio && o_clk_en) begin
              // Divider already runs at the requested ratio: acknowledge only.
              state <= ACK;
              o_ack <= gnt_oh;
            end else begin
              state    <= GATE;
              o_clk_en <= 1'b0;
              hold_cnt <= HOLD_TC;
            end
          end
        end
        GATE: begin
          if (hold_cnt == '0) begin
            state       <= LOAD;
            o_div_ratio <= ratio_q;
          end else begin
            hold_cnt <= hold_cnt - RATIO_W'(1);
          end
        end
        LOAD: begin
          state      <= SETTLE;
          o_clk_en   <= 1'b1;
          settle_cnt <= settle_terminal(ratio_q);
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            state <= ACK;
            o_ack <= owner_oh;
          end else begin
            settle_cnt <= settle_cnt - RATIO_W'(1);
          end
        end
        ACK: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl (NUM_REQ=2, HOLD_CYCLES=2).
`timescale 1ns/1ps
module tb_clk_div_ctrl;

  localparam int NUM_REQ = 2;
  localparam int HOLD    = 2;

  typedef struct {
    int         idx;
    logic [7:0] ratio;
    logic       clk_en;
    int         cyc;
    bit         nack;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req   = '0;
  logic [15:0] ratio_in = '0;
  logic [1:0]  ack;
  logic        busy;
  logic [0:0]  owner;
  logic        clk_en;
  logic [7:0]  div_ratio;
`ifdef CLK_DIV_CTRL_LOCK_EN
  logic        lock = 1'b0;
  logic [1:0]  nack;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q[$];

  clk_div_ctrl #(
    .NUM_REQ    (NUM_REQ),
    .HOLD_CYCLES(HOLD),
    .RESET_RATIO(8'd1)
  ) dut (
    .i_ref_clk  (clk),
    .i_rst_n    (rst_n),
`ifdef CLK_DIV_CTRL_LOCK_EN
    .i_cfg_lock (lock),
    .o_nack     (nack),
`endif
    .i_req      (req),
    .i_req_ratio(ratio_in),
    .o_ack      (ack),
    .o_busy     (busy),
    .o_owner    (owner),
    .o_clk_en   (clk_en),
    .o_div_ratio(div_ratio)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input int idx, input logic [7:0] r, input int exp_cyc,
                       input logic [7:0] exp_ratio, input logic exp_en, input bit nk);
    exp_t e;
    ratio_in[idx*8 +: 8] = r;
    req[idx] = 1'b1;
    e.idx = idx; e.ratio = exp_ratio; e.clk_en = exp_en; e.cyc = exp_cyc; e.nack = nk;
    q.push_back(e);
  endtask

  // Requester model: drop each request the cycle after its ack/nack appears.
  task automatic drop_acked();
    req = req & ~ack;
`ifdef CLK_DIV_CTRL_LOCK_EN
    req = req & ~nack;
`endif
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      drop_acked();
      n++;
    end
    chk("drain_before_timeout", q.size(), 0);
    q.delete();
    repeat (2) begin
      @(negedge clk);
      drop_acked();
    end
  endtask

  // Monitor: every ack/nack the DUT presents is matched against the queue head.
  exp_t       mon_e;
  logic [1:0] mon_nk;
  logic [1:0] mon_oh;
  always @(negedge clk) begin
    mon_nk = '0;
`ifdef CLK_DIV_CTRL_LOCK_EN
    mon_nk = nack;
`endif
    if (rst_n && (ack != '0 || mon_nk != '0)) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", {28'd0, mon_nk, ack}, 32'd0);
      end else begin
        mon_e  = q.pop_front();
        mon_oh = 2'b01 << mon_e.idx;
        chk("ack_vec",       ack,       mon_e.nack ? 2'b00 : mon_oh);
        chk("nack_vec",      mon_nk,    mon_e.nack ? mon_oh : 2'b00);
        chk("ack_cycle",     cyc,       mon_e.cyc);
        chk("ratio_at_ack",  div_ratio, mon_e.ratio);
        chk("clk_en_at_ack", clk_en,    mon_e.clk_en);
        chk("busy_at_ack",   busy,      1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_clk_en", clk_en, 0);
    chk("rst_ratio",  div_ratio, 1);
    chk("rst_busy",   busy, 0);
    chk("rst_ack",    ack, 0);
    chk("rst_owner",  owner, 1);

    // Basic change: ratio 4, ack at cycle 2+2+4 = 8.
    @(negedge clk);
    c = cyc;
    issue(0, 8'd4, c + 8, 8'd4, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k <= 7) begin
        chk("basic_clk_en", clk_en, (k >= 4) ? 1 : 0);
        chk("basic_ratio",  div_ratio, (k >= 3) ? 4 : 1);
      end
      chk("basic_busy", busy, 1);
      drop_acked();
    end
    run_until_idle(20);

    // Fast path: same ratio again, ack at cycle 1, enable never drops.
    c = cyc;
    issue(0, 8'd4, c + 1, 8'd4, 1'b1, 1'b0);
    @(negedge clk);
    chk("fast_clk_en1", clk_en, 1);
    drop_acked();
    @(negedge clk);
    chk("fast_busy_clear", busy, 0);
    chk("fast_clk_en2", clk_en, 1);
    run_until_idle(20);

    // Contention with owner=0: req1 (ratio 2) at cycle 6, then req0 (ratio 6).
    c = cyc;
    issue(1, 8'd2, c + 6,  8'd2, 1'b1, 1'b0);
    issue(0, 8'd6, c + 17, 8'd6, 1'b1, 1'b0);
    @(negedge clk);
    chk("contention_owner_first", owner, 1);
    run_until_idle(40);
    chk("contention_final_ratio", div_ratio, 6);
    chk("contention_final_owner", owner, 0);

    // Reset during SETTLE of a ratio-8 change: no ack may follow.
    c = cyc;
    ratio_in[15:8] = 8'd8;
    req[1] = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_in_settle", clk_en, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_clk_en", clk_en, 0);
    chk("midrst_ratio",  div_ratio, 1);
    chk("midrst_busy",   busy, 0);
    chk("midrst_ack",    ack, 0);
    chk("midrst_owner",  owner, 1);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    // Bypass ratios 0/1 settle for one cycle; ratio 255 settles 255 cycles.
    c = cyc;
    issue(0, 8'd0, c + 5, 8'd0, 1'b1, 1'b0);
    run_until_idle(30);
    c = cyc;
    issue(1, 8'd1, c + 5, 8'd1, 1'b1, 1'b0);
    run_until_idle(30);
    c = cyc;
    issue(0, 8'd1, c + 1, 8'd1, 1'b1, 1'b0);
    run_until_idle(30);
    c = cyc;
    issue(1, 8'd255, c + 259, 8'd255, 1'b1, 1'b0);
    run_until_idle(300);

`ifdef CLK_DIV_CTRL_LOCK_EN
    // Locked grant: nack at cycle 1, divider outputs untouched.
    lock = 1'b1;
    c = cyc;
    issue(0, 8'd8, c + 1, 8'd255, 1'b1, 1'b1);
    run_until_idle(20);
    lock = 1'b0;
    chk("lock_ratio_kept",  div_ratio, 255);
    chk("lock_clk_en_kept", clk_en, 1);
`endif

    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
